mem_arbiter2: RTL and testbench

//  Shares one single-port synchronous 32-bit memory between two masters.
//  M0 is the CPU fetch/load/store port; M1 is the UART program loader or debug port.
//  The block serialises accesses with a round-robin arbiter, drives the memory

---
 rtl/mem_arbiter2_pkg.sv | 14 +
 rtl/mem_arbiter2_arb_rr2.sv | 24 ++
 rtl/mem_arbiter2.sv | 110 +++++++++++
 tb/tb_mem_arbiter2.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter2_pkg.sv
// mem_arbiter2_pkg: shared FSM state type and master ids for the two-master memory arbiter
package mem_arbiter2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter2_arb_rr2.sv
// arb_rr2: two-way round-robin pick with a registered priority bit
module arb_rr2
    import mem_arbiter2_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_id
);

    logic prio;

    // a lone requester wins; on a tie the priority holder wins
    always_comb gnt_id = (&req) ? prio : req[1];

    // after each grant the loser holds priority for the next tie
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            prio <= M0;
        else if (grant_en && |req)
            prio <= ~gnt_id;

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: serialises two masters onto one single-port synchronous memory
module mem_arbiter2
    import mem_arbiter2_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              s_en,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wmask,
    input  logic [31:0]       s_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t            state, state_nx;
    logic              grant, gnt_id, id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [3:0]        wmask_q, cnt;

    assign grant = (state == IDLE) && (m0_valid || m1_valid);

    arb_rr2 u_arb (
        .clk      (clk),
        .resetn   (resetn),
        .req      ({m1_valid, m0_valid}),
        .grant_en (grant),
        .gnt_id   (gnt_id)
    );

    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wmask  = s_en ? wmask_q : 4'b0;
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

    // state register
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;

    // next state, memory strobe and completion pulses
    always_comb begin
        state_nx = state;
        s_en     = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        case (state)
            IDLE:  state_nx = grant ? ISSUE : IDLE;
            ISSUE: begin
                s_en     = 1'b1;
                state_nx = WAIT;
            end
            WAIT:  state_nx = (cnt == 4'd0) ? RESP : WAIT;
            RESP:  begin
                m0_ready = (id_q == M0);
                m1_ready = (id_q == M1);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // latch the winner and its payload at grant so later payload changes are ignored
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            id_q    <= M0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (grant) begin
            id_q    <= gnt_id;
            addr_q  <= (gnt_id == M1) ? m1_addr  : m0_addr;
            wdata_q <= (gnt_id == M1) ? m1_wdata : m0_wdata;
            wmask_q <= (gnt_id == M1) ? m1_wmask : m0_wmask;
        end

    // count out the memory latency and capture read data on the last wait cycle
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            if (state == ISSUE)
                cnt <= CNT_LOAD;
            else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd0 && wmask_q == 4'b0)
                rdata_q <= s_rdata;
        end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: randomized self-checking bench for mem_arbiter2 at LAT=1 and LAT=3
module tb_mem_arbiter2;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    // a master launches valid at the edge closing cycle 0, so valid is visible from cycle 1;
    // s_en is due in cycle 2 and ready in cycle LAT+3, i.e. that many edges minus one after launch
    localparam int EN_TICK = 2 - 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;

    logic        a_m0_ready, a_m1_ready, a_s_en;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_wdata, a_s_rdata;
    logic [7:0]  a_s_addr;
    logic [3:0]  a_s_wmask;
    logic        b_m0_ready, b_m1_ready, b_s_en;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_wdata, b_s_rdata;
    logic [7:0]  b_s_addr;
    logic [3:0]  b_s_wmask;

    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [31:0] poke_data;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] ref_mem [256];
    logic [31:0] b_p1, b_p2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter2 #(.ADDR_W(8), .LAT(LAT_A)) dut_a (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
        .s_en(a_s_en), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wmask(a_s_wmask),
        .s_rdata(a_s_rdata)
    );

    mem_arbiter2 #(.ADDR_W(8), .LAT(LAT_B)) dut_b (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
        .s_en(b_s_en), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wmask(b_s_wmask),
        .s_rdata(b_s_rdata)
    );

    // synchronous memories: read data is valid exactly LAT cycles after s_en, junk otherwise
    always @(posedge clk) begin
        if (poke_en) begin
            mem_a[poke_addr] <= poke_data;
            mem_b[poke_addr] <= poke_data;
        end
        if (a_s_en)
            for (int i = 0; i < 4; i++)
                if (a_s_wmask[i]) mem_a[a_s_addr][8*i +: 8] <= a_s_wdata[8*i +: 8];
        if (b_s_en)
            for (int i = 0; i < 4; i++)
                if (b_s_wmask[i]) mem_b[b_s_addr][8*i +: 8] <= b_s_wdata[8*i +: 8];
        a_s_rdata <= (a_s_en && a_s_wmask == 4'b0) ? mem_a[a_s_addr] : $urandom;
        b_p1      <= (b_s_en && b_s_wmask == 4'b0) ? mem_b[b_s_addr] : $urandom;
        b_p2      <= b_p1;
        b_s_rdata <= b_p2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        ref_mem[a] = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic set_req(input bit m, input logic [7:0] a, input logic [31:0] d, input logic [3:0] k);
        if (m) begin
            m1_addr = a; m1_wdata = d; m1_wmask = k; m1_valid = 1'b1;
        end else begin
            m0_addr = a; m0_wdata = d; m0_wmask = k; m0_valid = 1'b1;
        end
    endtask

    // one complete transfer on dut_a, checked against the reference memory and timing rules
    task automatic xfer(input bit m, input logic [7:0] a, input logic [31:0] d, input logic [3:0] k,
                        input string nm, output logic [31:0] rd);
        int n, en_n, en_at;
        bit got, other;
        logic [31:0] expd;
        expd = ref_mem[a];
        n = 0; en_n = 0; en_at = 0; got = 0; other = 0; rd = '0;
        set_req(m, a, d, k);
        while (!got && n < 20) begin
            tick(); n++;
            if (a_s_en) begin
                en_n++; en_at = n;
                checks++;
                if ({a_s_addr, a_s_wmask} !== {a, k} || (k != 4'b0 && a_s_wdata !== d)) begin
                    failures++;
                    $display("FAIL %s payload: addr=%h mask=%h wdata=%h want addr=%h mask=%h wdata=%h",
                             nm, a_s_addr, a_s_wmask, a_s_wdata, a, k, d);
                end
            end
            other |= m ? a_m0_ready : a_m1_ready;
            if (m ? a_m1_ready : a_m0_ready) begin
                got = 1; rd = m ? a_m1_rdata : a_m0_rdata;
            end
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();
        checks++;
        if (!got || n != LAT_A + 3 - 1) begin
            failures++; $display("FAIL %s latency: got=%0d edges=%0d want edges=%0d", nm, got, n, LAT_A + 2);
        end
        checks++;
        if (en_n != 1 || en_at != EN_TICK) begin
            failures++; $display("FAIL %s s_en: count=%0d at=%0d want count=1 at=%0d", nm, en_n, en_at, EN_TICK);
        end
        checks++;
        if (other !== 1'b0) begin
            failures++; $display("FAIL %s other_ready: got %b want 0", nm, other);
        end
        if (k == 4'b0) begin
            checks++;
            if (rd !== expd) begin
                failures++; $display("FAIL %s rdata: got %h want %h", nm, rd, expd);
            end
        end else
            for (int i = 0; i < 4; i++)
                if (k[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic test_reset();
        m0_valid = 0; m1_valid = 0; poke_en = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_wmask = 0; m1_wmask = 0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({a_s_en, a_s_wmask, a_m0_ready, a_m1_ready} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b want 0", {a_s_en, a_s_wmask, a_m0_ready, a_m1_ready});
        end
        tick();
        checks++;
        if ({a_s_addr, a_m0_rdata, a_m1_rdata} !== 72'b0) begin
            failures++; $display("FAIL reset_regs: got addr=%h rdata=%h/%h want 0", a_s_addr, a_m0_rdata, a_m1_rdata);
        end
        checks++;
        if ({b_s_en, b_m0_ready, b_m1_ready, b_m0_rdata, b_m1_rdata} !== 67'b0) begin
            failures++; $display("FAIL reset_lat3: got en=%b rdy=%b%b rdata=%h/%h want 0",
                                 b_s_en, b_m0_ready, b_m1_ready, b_m0_rdata, b_m1_rdata);
        end
        resetn = 1'b1;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    endtask

    task automatic test_single_read();
        logic [31:0] rd;
        poke(8'h05, 32'hDEADBEEF);
        xfer(1'b0, 8'h05, $urandom, 4'b0, "single_read", rd);
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        poke(8'h10, 32'h11223344);
        xfer(1'b1, 8'h10, 32'h000000AB, 4'b0001, "byte_write", rd);
        xfer(1'b1, 8'h10, $urandom, 4'b0, "byte_readback", rd);
        checks++;
        if (rd !== 32'h112233AB) begin
            failures++; $display("FAIL byte_merge: got %h want 112233ab", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        repeat (24) begin
            xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0, "random", rd);
        end
    endtask

    task automatic test_contention();
        int g, n;
        bit both;
        bit seq [4];
        set_req(1'b0, 8'h20, 0, 4'b0);
        set_req(1'b1, 8'h21, 0, 4'b0);
        do_reset();
        g = 0; n = 0; both = 0;
        while (g < 4 && n < 40) begin
            tick(); n++;
            both |= a_m0_ready & a_m1_ready;
            if (a_m0_ready || a_m1_ready) begin
                seq[g] = a_m1_ready;
                checks++;
                if (a_m0_rdata !== ref_mem[a_m1_ready ? 8'h21 : 8'h20]) begin
                    failures++; $display("FAIL contention_rdata: got %h want %h",
                                         a_m0_rdata, ref_mem[a_m1_ready ? 8'h21 : 8'h20]);
                end
                g++;
            end
        end
        m0_valid = 0; m1_valid = 0;
        tick();
        checks++;
        if (g != 4 || both) begin
            failures++; $display("FAIL contention_count: grants=%0d both=%b want 4 grants, both=0", g, both);
        end
        for (int i = 0; i < g; i++) begin
            checks++;
            if (seq[i] !== 1'(i % 2)) begin
                failures++; $display("FAIL contention_order[%0d]: got M%0d want M%0d", i, seq[i], i % 2);
            end
        end
    endtask

    task automatic test_latency();
        int n, en_n, en_at, rt;
        bit oth;
        logic [31:0] k, rd;
        m0_valid = 0; m1_valid = 0;
        do_reset();
        k = $urandom;
        poke(8'h33, k);
        set_req(1'b0, 8'h33, 0, 4'b0);
        n = 0; en_n = 0; en_at = 0; rt = 0; oth = 0; rd = 0;
        while (rt == 0 && n < 20) begin
            tick(); n++;
            if (b_s_en) begin en_n++; en_at = n; end
            oth |= b_m1_ready;
            if (b_m0_ready) begin rt = n; rd = b_m0_rdata; end
        end
        m0_valid = 0;
        checks++;
        if (rt != LAT_B + 3 - 1) begin
            failures++; $display("FAIL lat3_ready: edges=%0d want %0d", rt, LAT_B + 2);
        end
        checks++;
        if (en_n != 1 || en_at != EN_TICK) begin
            failures++; $display("FAIL lat3_s_en: count=%0d at=%0d want count=1 at=%0d", en_n, en_at, EN_TICK);
        end
        checks++;
        if (rd !== k || oth) begin
            failures++; $display("FAIL lat3_rdata: got %h m1_ready=%b want %h m1_ready=0", rd, oth, k);
        end
    endtask

    task automatic test_reset_mid();
        int g, n;
        bit seq [2];
        logic [31:0] rd;
        m0_valid = 0; m1_valid = 0;
        do_reset();
        xfer(1'b0, 8'h05, 0, 4'b0, "pre_reset_read", rd);
        set_req(1'b0, 8'h40, 0, 4'b0);
        tick(); tick();
        resetn = 1'b0;
        set_req(1'b1, 8'h41, 0, 4'b0);
        #1;
        checks++;
        if ({a_s_en, a_m0_ready, a_m1_ready} !== 3'b0 || a_m0_rdata !== 32'b0) begin
            failures++; $display("FAIL reset_mid_now: en=%b rdy=%b%b rdata=%h want 0", a_s_en, a_m0_ready, a_m1_ready, a_m0_rdata);
        end
        repeat (3) begin
            tick();
            checks++;
            if ({a_s_en, a_m0_ready, a_m1_ready} !== 3'b0) begin
                failures++; $display("FAIL reset_mid_hold: en=%b rdy=%b%b want 0", a_s_en, a_m0_ready, a_m1_ready);
            end
        end
        resetn = 1'b1;
        g = 0; n = 0;
        while (g < 2 && n < 30) begin
            tick(); n++;
            if (a_m0_ready || a_m1_ready) begin
                seq[g] = a_m1_ready;
                if (a_m1_ready) m1_valid = 0; else m0_valid = 0;
                checks++;
                if (a_m0_rdata !== ref_mem[a_m1_ready ? 8'h41 : 8'h40]) begin
                    failures++; $display("FAIL reset_mid_rdata: got %h want %h",
                                         a_m0_rdata, ref_mem[a_m1_ready ? 8'h41 : 8'h40]);
                end
                g++;
            end
        end
        m0_valid = 0; m1_valid = 0;
        tick();
        checks++;
        if (g != 2 || seq[0] !== 1'b0 || seq[1] !== 1'b1) begin
            failures++; $display("FAIL reset_mid_order: grants=%0d first=M%0d second=M%0d want 2, M0 then M1", g, seq[0], seq[1]);
        end
    endtask

    task automatic test_payload();
        logic [31:0] rd;
        m0_valid = 0; m1_valid = 0;
        do_reset();
        poke(8'h60, 32'hA5A50060);
        poke(8'h61, 32'h5A5A0061);
        set_req(1'b0, 8'h60, 0, 4'b0);
        tick(); tick();
        set_req(1'b0, 8'h61, $urandom, 4'hF);
        #1;
        checks++;
        if (a_s_addr !== 8'h60) begin
            failures++; $display("FAIL payload_addr: got %h want 60", a_s_addr);
        end
        tick();
        checks++;
        if (a_m0_ready !== 1'b1 || a_m0_rdata !== ref_mem[8'h60]) begin
            failures++; $display("FAIL payload_rdata: ready=%b rdata=%h want ready=1 rdata=%h", a_m0_ready, a_m0_rdata, ref_mem[8'h60]);
        end
        m0_valid = 0;
        tick();
        xfer(1'b0, 8'h61, 0, 4'b0, "payload_untouched", rd);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_random();
        test_contention();
        test_latency();
        test_reset_mid();
        test_payload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
